// File: rtl/delay_calib_pkg.sv
// -----------------------------------------------------------------------------
// delay_calib_pkg
// Shared definitions for the delay calibrator: the controller state encoding
// and the result codes reported on err_o.
// -----------------------------------------------------------------------------
package delay_calib_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_REF,
    COUNT,
    NEXT,
    DONE
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'd0;  // measurement valid
  localparam logic [1:0] ERR_NOREF    = 2'd1;  // no reference crossing in time
  localparam logic [1:0] ERR_OVF      = 2'd2;  // delay beyond 2**SW-1
  localparam logic [1:0] ERR_MISMATCH = 2'd3;  // repeated measurements disagree

endpackage

// File: rtl/delay_calib_if.sv
// -----------------------------------------------------------------------------
// delay_calib_if
// Control and sample bundle of the delay calibrator.
//   start_i : calibration request (level, accepted when idle)
//   thr_i   : signed crossing threshold, latched at accept
//   ref_i   : signed reference stream (before the delay line)
//   dly_i   : signed delayed stream (after the delay line)
//   busy_o  : calibration in progress
//   done_o  : one-cycle end-of-calibration pulse
//   sel_o   : measured tap select, held until the next done_o
//   err_o   : result code (see delay_calib_pkg)
// master = software / stream side, slave = calibrator.
// -----------------------------------------------------------------------------
interface delay_calib_if #(
  parameter int DW = 14,
  parameter int SW = 4
);
  logic                 start_i;
  logic signed [DW-1:0] thr_i;
  logic signed [DW-1:0] ref_i;
  logic signed [DW-1:0] dly_i;
  logic                 busy_o;
  logic                 done_o;
  logic [SW-1:0]        sel_o;
  logic [1:0]           err_o;

  modport master (
    output start_i, thr_i, ref_i, dly_i,
    input  busy_o, done_o, sel_o, err_o
  );

  modport slave (
    input  start_i, thr_i, ref_i, dly_i,
    output busy_o, done_o, sel_o, err_o
  );
endinterface

// File: rtl/delay_calib_xdet.sv
// -----------------------------------------------------------------------------
// delay_calib_xdet
// Rising threshold-crossing detector for one registered sample stream.
//   clk, rstn : clock, asynchronous active-low reset
//   prime_i   : high during the priming cycle; suppresses detection while the
//               previous-sample register is being refreshed
//   thr_i     : signed threshold
//   cur_i     : current (already registered) sample
//   cross_o   : combinational, prev < thr && cur >= thr (signed)
// -----------------------------------------------------------------------------
module delay_calib_xdet #(
  parameter int DW = 14
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 prime_i,
  input  logic signed [DW-1:0] thr_i,
  input  logic signed [DW-1:0] cur_i,
  output logic                 cross_o
);

  logic signed [DW-1:0] prev_q;
  logic                 valid_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prev_q <= cur_i;
      // prev is meaningless until the stream has been primed once
      if (prime_i) valid_q <= 1'b1;
    end
  end

  assign cross_o = valid_q && !prime_i && (prev_q < thr_i) && (cur_i >= thr_i);

endmodule

// File: rtl/delay_calib.sv
// -----------------------------------------------------------------------------
// delay_calib
// Measures the latency, in clk cycles, between a reference sample stream and
// its delayed copy, repeated NMEAS times, and reports a tap select for the
// delay line.
//   clk, rstn : sample clock, asynchronous active-low reset
//   bus       : delay_calib_if.slave (start/threshold/streams in,
//               busy/done/select/error out)
// Build option DELAY_CALIB_AVG_EN: when defined, the NMEAS delays are averaged
// (round half up) instead of required to agree; err_o never reports mismatch.
// -----------------------------------------------------------------------------
module delay_calib
  import delay_calib_pkg::*;
#(
  parameter int DW     = 14,
  parameter int SW     = 4,
  parameter int NMEAS  = 4,
  parameter int REF_TO = 65535
) (
  input  logic          clk,
  input  logic          rstn,
  delay_calib_if.slave  bus
);

  localparam int LOG2N = $clog2(NMEAS);
  localparam int IW    = (LOG2N > 0) ? LOG2N : 1;
  localparam int WW    = $clog2(REF_TO + 1);
  localparam logic [SW-1:0] MAXD     = '1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NMEAS - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(REF_TO - 1);

  state_t               state;
  logic signed [DW-1:0] ref_q, dly_q, thr_q;
  logic                 ref_x, dly_x;
  logic [IW-1:0]        idx;
  logic [WW-1:0]        wd;
  logic [SW-1:0]        cnt, meas;
  logic [SW-1:0]        fin_sel;
  logic [1:0]           fin_err;

  // One register on each stream keeps their relative delay intact.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ref_q <= '0;
      dly_q <= '0;
    end else begin
      ref_q <= bus.ref_i;
      dly_q <= bus.dly_i;
    end
  end

  delay_calib_xdet #(.DW(DW)) u_ref_xdet (
    .clk(clk), .rstn(rstn), .prime_i(state == ARM),
    .thr_i(thr_q), .cur_i(ref_q), .cross_o(ref_x)
  );

  delay_calib_xdet #(.DW(DW)) u_dly_xdet (
    .clk(clk), .rstn(rstn), .prime_i(state == ARM),
    .thr_i(thr_q), .cur_i(dly_q), .cross_o(dly_x)
  );

`ifdef DELAY_CALIB_AVG_EN
  localparam int ACW = SW + LOG2N;
  logic [ACW-1:0] acc, sum, rnd;

  // NOTE: every combinational output gets a value before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sum     = acc + ACW'(meas);
    rnd     = sum + ACW'(NMEAS / 2);
    fin_sel = rnd[ACW-1 -: SW];
    fin_err = ERR_OK;
  end
`else
  logic [SW-1:0] ref_val;
  logic          mism, first, mism_nx;

  always_comb begin
    first   = (idx == '0);
    mism_nx = mism | (!first && (meas != ref_val));
    fin_sel = first ? meas : ref_val;
    fin_err = mism_nx ? ERR_MISMATCH : ERR_OK;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      thr_q      <= '0;
      idx        <= '0;
      wd         <= '0;
      cnt        <= '0;
      meas       <= '0;
`ifdef DELAY_CALIB_AVG_EN
      acc        <= '0;
`else
      ref_val    <= '0;
      mism       <= 1'b0;
`endif
      bus.busy_o <= 1'b0;
      bus.done_o <= 1'b0;
      bus.sel_o  <= '0;
      bus.err_o  <= ERR_OK;
    end else begin
      bus.done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            thr_q      <= bus.thr_i;
            idx        <= '0;
`ifdef DELAY_CALIB_AVG_EN
            acc        <= '0;
`else
            mism       <= 1'b0;
`endif
            bus.busy_o <= 1'b1;
            state      <= ARM;
          end
        end
        ARM: begin
          wd    <= '0;
          state <= WAIT_REF;
        end
        WAIT_REF: begin
          if (ref_x) begin
            cnt <= '0;
            if (dly_x) begin
              meas  <= '0;
              state <= NEXT;
            end else begin
              state <= COUNT;
            end
          end else if (wd == WD_LAST) begin
            bus.err_o  <= ERR_NOREF;
            bus.done_o <= 1'b1;
            bus.busy_o <= 1'b0;
            state      <= DONE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        COUNT: begin
          // cnt == MAXD means this cycle's delay would be 2**SW: unrepresentable
          if (cnt == MAXD) begin
            bus.err_o  <= ERR_OVF;
            bus.done_o <= 1'b1;
            bus.busy_o <= 1'b0;
            state      <= DONE;
          end else if (dly_x) begin
            meas  <= cnt + 1'b1;
            state <= NEXT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        NEXT: begin
`ifdef DELAY_CALIB_AVG_EN
          acc <= sum;
`else
          if (first) ref_val <= meas;
          mism <= mism_nx;
`endif
          if (idx == LAST_IDX) begin
            bus.err_o  <= fin_err;
            if (fin_err == ERR_OK) bus.sel_o <= fin_sel;
            bus.done_o <= 1'b1;
            bus.busy_o <= 1'b0;
            state      <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ARM;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_calib.sv
// -----------------------------------------------------------------------------
// tb_delay_calib
// Self-checking bench for delay_calib. Each calibration drives a waveform with
// one reference rising edge per measurement slot and a delayed copy; expected
// results come from a table or from a waveform-level model that locates
// crossings and takes index differences.
// -----------------------------------------------------------------------------
module tb_delay_calib;
  import delay_calib_pkg::*;

  localparam int DW         = 14;
  localparam int SW         = 4;
  localparam int NMEAS      = 4;
  localparam int REF_TO     = 65535;
  localparam int MAXD       = (1 << SW) - 1;
  localparam int PER        = 40;
  localparam int LEAD       = 10;
  localparam int HIGH       = 20;
  localparam int WLEN       = LEAD + PER * NMEAS;
  localparam int RUN_BUDGET = WLEN + 40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  delay_calib_if #(.DW(DW), .SW(SW)) bus ();

  delay_calib #(.DW(DW), .SW(SW), .NMEAS(NMEAS), .REF_TO(REF_TO)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct packed {
    int d0, d1, d2, d3;
    int early;
    int thr;
    int exp_sel;
    int exp_err;
  } vec_t;

  vec_t vecs [8];

  int checks = 0;
  int errors = 0;

  int wave_ref [WLEN];
  int wave_dly [WLEN];
  int cur_d [NMEAS];
  int cur_early, cur_thr;
  bit noisy;
  int prev_sel = 0;
  int restart_at = -1;
  int rst_at = -1;
  int ndone, got_sel, got_err, done_k, busy_at_done, busy_early;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lvl(input bit high);
    if (!noisy) return high ? 1000 : -1000;
    if (high) return cur_thr + int'($urandom_range(0, 2999));
    return cur_thr - 1 - int'($urandom_range(0, 2999));
  endfunction

  task automatic build_wave();
    for (int i = 0; i < WLEN; i++) begin
      wave_ref[i] = lvl(1'b0);
      wave_dly[i] = lvl(1'b0);
    end
    for (int j = 0; j < NMEAS; j++) begin
      int base;
      base = LEAD + PER * j;
      for (int i = base; i < base + HIGH; i++) wave_ref[i] = lvl(1'b1);
      for (int i = base + cur_d[j]; i < base + cur_d[j] + HIGH && i < WLEN; i++)
        wave_dly[i] = lvl(1'b1);
      if (cur_early != 0) begin
        wave_dly[base-3] = lvl(1'b1);
        wave_dly[base-2] = lvl(1'b1);
      end
    end
  endtask

  task automatic const_wave(input int v);
    for (int i = 0; i < WLEN; i++) begin
      wave_ref[i] = v;
      wave_dly[i] = v;
    end
  endtask

  function automatic bit xing(input int p, input int c);
    return (p < cur_thr) && (c >= cur_thr);
  endfunction

  // Waveform-level reference: the j-th reference rising edge pairs with the
  // first delayed rising edge at or after it; delay is the index distance.
  task automatic model(output int es, output int ee);
    int pos, r, q, sum;
    int dl [NMEAS];
    bit all_eq;
    pos = 1;
    sum = 0;
    all_eq = 1'b1;
    for (int j = 0; j < NMEAS; j++) begin
      r = -1;
      for (int i = pos; i < WLEN && r < 0; i++)
        if (xing(wave_ref[i-1], wave_ref[i])) r = i;
      if (r < 0) begin
        es = prev_sel; ee = 1; return;
      end
      q = -1;
      for (int i = r; i < WLEN && q < 0; i++)
        if (xing(wave_dly[i-1], wave_dly[i])) q = i;
      if (q < 0 || q - r > MAXD) begin
        es = prev_sel; ee = 2; return;
      end
      dl[j] = q - r;
      sum += dl[j];
      if (dl[j] != dl[0]) all_eq = 1'b0;
      pos = r + 1;
    end
`ifdef DELAY_CALIB_AVG_EN
    es = (sum + NMEAS / 2) / NMEAS;
    ee = 0;
`else
    if (all_eq) begin es = dl[0]; ee = 0; end
    else begin es = prev_sel; ee = 3; end
`endif
  endtask

  task automatic run_cal(input int budget);
    int w;
    ndone = 0; got_sel = -1; got_err = -1; done_k = -1;
    busy_at_done = -1; busy_early = -1;
    bus.thr_i = DW'(cur_thr);
    repeat (4) begin
      @(negedge clk);
      bus.ref_i = DW'(wave_ref[0]);
      bus.dly_i = DW'(wave_dly[0]);
    end
    @(negedge clk);
    bus.start_i = 1'b1;
    for (int k = 1; k < budget; k++) begin
      @(negedge clk);
      bus.start_i = (k == restart_at);
      if (k == rst_at) begin
        check("rst_busy_before", int'(bus.busy_o), 1);
        rstn = 1'b0;
        #1;
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_sel", int'(bus.sel_o), 0);
        check("rst_err", int'(bus.err_o), 0);
      end
      if (k == rst_at + 2) rstn = 1'b1;
      if (k == 2) busy_early = int'(bus.busy_o);
      if (bus.done_o) begin
        ndone++;
        if (ndone == 1) begin
          got_sel = int'(bus.sel_o);
          got_err = int'(bus.err_o);
          busy_at_done = int'(bus.busy_o);
          done_k = k;
        end
      end
      w = (k < WLEN) ? k : WLEN - 1;
      bus.ref_i = DW'(wave_ref[w]);
      bus.dly_i = DW'(wave_dly[w]);
      if (k >= WLEN + 4 && (ndone > 0 || rst_at >= 0)) break;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic check_cal(input string name, input int es, input int ee);
    check({name, "_ndone"}, ndone, 1);
    check({name, "_sel"}, got_sel, es);
    check({name, "_err"}, got_err, ee);
    check({name, "_busy"}, busy_early, 1);
    check({name, "_busy_at_done"}, busy_at_done, 0);
  endtask

  initial begin
    int es, ee, basev;
    bus.start_i = 1'b0;
    bus.thr_i = '0;
    bus.ref_i = '0;
    bus.dly_i = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy_o), 0);
    check("reset_done", int'(bus.done_o), 0);
    check("reset_sel", int'(bus.sel_o), 0);
    check("reset_err", int'(bus.err_o), 0);
    rstn = 1'b1;

    //          d0  d1  d2  d3 early  thr  sel err
    vecs[0] = '{ 7,  7,  7,  7, 0,     0,   7,  0};
    vecs[1] = '{ 0,  0,  0,  0, 0,     0,   0,  0};
    vecs[2] = '{15, 15, 15, 15, 0,   300,  15,  0};
    vecs[3] = '{16, 16, 16, 16, 0,     0,  15,  2};
`ifdef DELAY_CALIB_AVG_EN
    vecs[4] = '{ 5,  5,  6,  5, 0,     0,   5,  0};
`else
    vecs[4] = '{ 5,  5,  6,  5, 0,     0,  15,  3};
`endif
    vecs[5] = '{ 4,  4,  4,  4, 1,  -200,   4,  0};
    vecs[6] = '{ 3, 16,  3,  3, 0,     0,   4,  2};
`ifdef DELAY_CALIB_AVG_EN
    vecs[7] = '{ 2,  9,  2,  2, 0,     0,   4,  0};
`else
    vecs[7] = '{ 2,  9,  2,  2, 0,     0,   4,  3};
`endif

    noisy = 1'b0;
    for (int v = 0; v < 8; v++) begin
      cur_d[0] = vecs[v].d0; cur_d[1] = vecs[v].d1;
      cur_d[2] = vecs[v].d2; cur_d[3] = vecs[v].d3;
      cur_early = vecs[v].early;
      cur_thr = vecs[v].thr;
      build_wave();
      run_cal(RUN_BUDGET);
      check_cal($sformatf("vec%0d", v), vecs[v].exp_sel, vecs[v].exp_err);
      prev_sel = vecs[v].exp_sel;
    end

    // Reference parked above threshold: watchdog expiry.
    cur_thr = 0;
    const_wave(500);
    run_cal(REF_TO + 100);
    check_cal("timeout", prev_sel, int'(ERR_NOREF));
    check("timeout_latency", int'(done_k >= REF_TO && done_k <= REF_TO + 4), 1);

    // start_i re-pulsed while counting must not restart the calibration.
    for (int j = 0; j < NMEAS; j++) cur_d[j] = 7;
    cur_early = 0;
    build_wave();
    restart_at = 13;
    run_cal(RUN_BUDGET);
    restart_at = -1;
    check_cal("restart_ignored", 7, 0);
    prev_sel = 7;

    // Reset in the middle of COUNT: outputs clear at once, no done_o.
    for (int j = 0; j < NMEAS; j++) cur_d[j] = 9;
    build_wave();
    rst_at = 14;
    run_cal(RUN_BUDGET);
    rst_at = -1;
    check("rst_no_done", ndone, 0);
    check("rst_sel_after", int'(bus.sel_o), 0);
    prev_sel = 0;

    // Recovery after reset, with an early delayed edge in every slot.
    for (int j = 0; j < NMEAS; j++) cur_d[j] = 4;
    cur_early = 1;
    build_wave();
    run_cal(RUN_BUDGET);
    check_cal("recover_early", 4, 0);
    prev_sel = 4;

    // Randomized levels, thresholds and delays against the waveform model.
    noisy = 1'b1;
    for (int r = 0; r < 20; r++) begin
      cur_thr = int'($urandom_range(0, 6000)) - 3000;
      basev = int'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) basev = 16;
      for (int j = 0; j < NMEAS; j++)
        cur_d[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : basev;
      cur_early = int'($urandom_range(0, 1));
      build_wave();
      model(es, ee);
      run_cal(RUN_BUDGET);
      check_cal($sformatf("rand%0d", r), es, ee);
      prev_sel = es;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
